oam_dma_m: RTL and testbench
============================

OAM_DMA_M -- requirements
Module: oam_dma_m

Interface
REQ-001 Parameter LEN, default 160; number of bytes copied per transfer.
REQ-002 Parameter START_DELAY, default 1; ticks between the trigger write and the first byte copy.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 tick  input  1  machine-cycle enable; at most one byte is copied per tick.
REQ-006 reg_write  input  1  one-cycle strobe writing the DMA source-page register.
REQ-007 d_wr  input  8  write data (source page, high address byte).
REQ-008 reg_d_rd  output  8  last value written to the source-page register.
REQ-009 src_addr  output  16  source read address.
REQ-010 src_rd  output  1  source read strobe.
REQ-011 src_d  input  8  source data, valid combinationally in the same clk cycle as src_rd (memory clocked on the opposite edge).
REQ-012 oam_addr  output  8  OAM byte write address.
REQ-013 oam_d  output  8  OAM write data.
REQ-014 oam_write  output  1  OAM write strobe.
REQ-015 active  output  1  high while a copy owns the bus; the PPU/CPU arbiter blocks CPU OAM and source-bus access while it is high.

Function
REQ-016 States: S_IDLE, S_START, S_XFER.
REQ-017 reg_write in any state: the register latches d_wr, the start countdown loads START_DELAY, and the state becomes S_START.
REQ-018 S_START: the countdown decrements on each tick; on the tick where it reaches 0 the state becomes S_XFER and the byte index resets to 0.
REQ-019 S_XFER, on a tick: src_rd=1, oam_write=1, oam_d=src_d, oam_addr=index, src_addr={page,index}; index then increments.
REQ-020 S_XFER, no tick: src_rd=0 and oam_write=0; index is held.
REQ-021 S_XFER, tick at index LEN-1: the last byte is written, then the state returns to S_IDLE.
REQ-022 Page mapping: page >= 8'hE0 uses page-8'h20 (echo region); all other pages are used unchanged.
REQ-023 active=1 in S_XFER; active=1 in S_START only when a copy was in S_XFER when the restart was written.
REQ-024 Restart during S_XFER:
- the old copy keeps writing (old page, continuing index) until the countdown expires;
- the new copy then starts at index 0 with the new page.
REQ-025 reg_write and tick in the same cycle: the write wins; no countdown decrement or byte copy occurs in that cycle.
REQ-026 reg_write while in S_START: the countdown reloads and the new page replaces the pending one.
REQ-027 Index width is 8 bits; LEN <= 256; arithmetic wraps mod 256 and never exceeds LEN-1.
REQ-028 src_rd, oam_write and the strobe outputs are combinational decodes of state AND tick; no output is driven from a stale tick.
REQ-029 reg_d_rd reads the latched page with zero latency.

Reset
REQ-030 On rst: state=S_IDLE, index=0, countdown=0, page register=8'hFF.
REQ-031 On rst: active, src_rd and oam_write deassert asynchronously.
REQ-032 Reset mid-transfer abandons the copy; already-written OAM bytes are left as written.
REQ-033 After rst deasserts, the first reg_write behaves identically to a cold start.

Structure
REQ-034 The shared package holds:
- dma_state_t enum;
- register-index constant DMA = 4'h6, added to the existing PPU register enum (ppu_reg_t);
- constant OAM_BYTES = 160.
REQ-035 Single module with no sub-module; the tick divider stays outside, in the PPU top.

Verification
REQ-036 Write 8'hC1, tick every 4 clk -> after 1 tick delay, 160 writes: oam_addr 0..159, src_addr 16'hC100..16'hC19F, then active=0.
REQ-037 Write 8'hFE -> src_addr starts at 16'hDE00; reg_d_rd=8'hFE.
REQ-038 Rewrite 8'h80 at index 50 -> old copy writes index 50 at page C1, then restarts at index 0 with src_addr 16'h8000; active never drops.
REQ-039 Gaps in tick during S_XFER -> no writes and index held; the copy completes with exactly 160 oam_write pulses.
REQ-040 Assert rst at index 100 -> active, oam_write and src_rd drop without waiting for clk; reg_d_rd=8'hFF; state S_IDLE.
REQ-041 reg_write coinciding with a tick in S_IDLE -> no copy that cycle; the first write occurs START_DELAY+1 ticks later.

Source files
------------

// File: rtl/oam_dma_m_pkg.sv
// Shared PPU definitions: register map, DMA controller state encoding and
// the source-page echo mapping used by the OAM DMA engine.
package oam_dma_m_pkg;

    localparam int OAM_BYTES = 160;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_XFER  = 2'd2
    } dma_state_t;

    typedef enum logic [3:0] {
        LCDC = 4'h0,
        STAT = 4'h1,
        SCY  = 4'h2,
        SCX  = 4'h3,
        LY   = 4'h4,
        LYC  = 4'h5,
        DMA  = 4'h6,
        BGP  = 4'h7,
        OBP0 = 4'h8,
        OBP1 = 4'h9,
        WY   = 4'hA,
        WX   = 4'hB
    } ppu_reg_t;

    // Pages in the echo region alias work RAM 8 KiB lower.
    function automatic logic [7:0] map_page(input logic [7:0] page);
        logic [7:0] mapped;
        if (page >= 8'hE0) begin
            mapped = page - 8'h20;
        end else begin
            mapped = page;
        end
        return mapped;
    endfunction

endpackage

// File: rtl/oam_dma_m.sv
// OAM DMA engine: copies LEN bytes from {page,index} into OAM, one byte per
// tick, with a restart that lets the running copy continue until the new one starts.
module oam_dma_m
    import oam_dma_m_pkg::*;
#(
    parameter int LEN         = OAM_BYTES,
    parameter int START_DELAY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        reg_write,
    input  logic [7:0]  d_wr,
    output logic [7:0]  reg_d_rd,
    output logic [15:0] src_addr,
    output logic        src_rd,
    input  logic [7:0]  src_d,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_d,
    output logic        oam_write,
    output logic        active
);

    localparam logic [7:0] LAST_IDX = 8'(LEN - 1);
    localparam logic [7:0] DELAY    = 8'(START_DELAY);

    dma_state_t state_r, state_s;
    logic [7:0] page_r, page_s;
    logic [7:0] xfer_page_r, xfer_page_s;
    logic [7:0] index_r, index_s;
    logic [7:0] count_r, count_s;
    // overlap_r: the pending start interrupted a running copy (keeps active high).
    // old_busy_r: that interrupted copy still has bytes left to write.
    logic       overlap_r, overlap_s;
    logic       old_busy_r, old_busy_s;
    logic       copy_s;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            page_r      <= 8'hFF;
            xfer_page_r <= 8'h00;
            index_r     <= 8'h00;
            count_r     <= 8'h00;
            overlap_r   <= 1'b0;
            old_busy_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            page_r      <= page_s;
            xfer_page_r <= xfer_page_s;
            index_r     <= index_s;
            count_r     <= count_s;
            overlap_r   <= overlap_s;
            old_busy_r  <= old_busy_s;
        end
    end

    // Next-state logic and per-tick copy decision.
    always_comb begin
        state_s     = state_r;
        page_s      = page_r;
        xfer_page_s = xfer_page_r;
        index_s     = index_r;
        count_s     = count_r;
        overlap_s   = overlap_r;
        old_busy_s  = old_busy_r;
        copy_s      = 1'b0;

        if (reg_write) begin
            page_s  = d_wr;
            count_s = DELAY;
            state_s = S_START;
            case (state_r)
                S_XFER: begin
                    overlap_s  = 1'b1;
                    old_busy_s = 1'b1;
                end
                S_START: begin
                    overlap_s  = overlap_r;
                    old_busy_s = old_busy_r;
                end
                default: begin
                    overlap_s  = 1'b0;
                    old_busy_s = 1'b0;
                end
            endcase
        end else if (tick) begin
            case (state_r)
                S_START: begin
                    copy_s = old_busy_r;
                    if (old_busy_r) begin
                        if (index_r == LAST_IDX) begin
                            old_busy_s = 1'b0;
                            index_s    = 8'h00;
                        end else begin
                            index_s    = index_r + 8'd1;
                        end
                    end else begin
                        index_s = index_r;
                    end
                    if (count_r <= 8'd1) begin
                        count_s     = 8'h00;
                        state_s     = S_XFER;
                        index_s     = 8'h00;
                        xfer_page_s = map_page(page_r);
                        overlap_s   = 1'b0;
                        old_busy_s  = 1'b0;
                    end else begin
                        count_s = count_r - 8'd1;
                    end
                end
                S_XFER: begin
                    copy_s = 1'b1;
                    if (index_r == LAST_IDX) begin
                        state_s = S_IDLE;
                        index_s = 8'h00;
                    end else begin
                        index_s = index_r + 8'd1;
                    end
                end
                default: begin
                    state_s = state_r;
                end
            endcase
        end else begin
            copy_s = 1'b0;
        end
    end

    // Strobes come straight from the reset-cleared state, so rst drops them at once.
    assign src_rd    = copy_s;
    assign oam_write = copy_s;
    assign oam_addr  = index_r;
    assign oam_d     = src_d;
    assign src_addr  = {xfer_page_r, index_r};
    assign reg_d_rd  = page_r;
    assign active    = (state_r == S_XFER) || ((state_r == S_START) && overlap_r);

endmodule

// File: tb/tb_oam_dma_m.sv
// Randomized scoreboard bench for oam_dma_m against a copy-level reference model.
module tb_oam_dma_m;

    localparam int LEN = 160;
    localparam int SD  = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        reg_write = 1'b0;
    logic [7:0]  d_wr = 8'h00;
    logic [7:0]  reg_d_rd;
    logic [15:0] src_addr;
    logic        src_rd;
    logic [7:0]  src_d;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_d;
    logic        oam_write;
    logic        active;

    oam_dma_m #(.LEN(LEN), .START_DELAY(SD)) dut (
        .clk(clk), .rst(rst), .tick(tick), .reg_write(reg_write), .d_wr(d_wr),
        .reg_d_rd(reg_d_rd), .src_addr(src_addr), .src_rd(src_rd), .src_d(src_d),
        .oam_addr(oam_addr), .oam_d(oam_d), .oam_write(oam_write), .active(active)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    assign src_d = mem(src_addr);

    typedef struct packed {
        logic [7:0]  oa;
        logic [15:0] sa;
        logic [7:0]  dd;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    bit   mon_en = 1'b0;

    // Reference model: one running copy plus at most one pending start.
    bit         cur_valid = 1'b0;
    bit         pend_valid = 1'b0;
    bit         hold = 1'b0;
    int         cur_idx = 0;
    int         pend_left = 0;
    logic [7:0] cur_page = 8'h00;
    logic [7:0] m_page = 8'hFF;
    logic       exp_active = 1'b0;
    logic       exp_write = 1'b0;
    logic [7:0] exp_page = 8'hFF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model(input logic w, input logic t, input logic [7:0] d);
        logic [7:0]  ix;
        logic [15:0] sa;
        exp_active = (cur_valid && !pend_valid) || (pend_valid && hold);
        exp_page   = m_page;
        exp_write  = 1'b0;
        if (w) begin
            hold       = pend_valid ? hold : cur_valid;
            m_page     = d;
            pend_valid = 1'b1;
            pend_left  = SD;
        end else if (t) begin
            if (cur_valid) begin
                exp_write = 1'b1;
                ix = 8'(cur_idx);
                sa = {cur_page, ix};
                q.push_back('{oa: ix, sa: sa, dd: mem(sa)});
                cur_idx++;
                if (cur_idx == LEN) cur_valid = 1'b0;
            end
            if (pend_valid) begin
                if (pend_left <= 1) begin
                    pend_valid = 1'b0;
                    hold       = 1'b0;
                    cur_valid  = 1'b1;
                    cur_idx    = 0;
                    cur_page   = (m_page >= 8'hE0) ? m_page - 8'h20 : m_page;
                end else begin
                    pend_left--;
                end
            end
        end
    endtask

    task automatic model_reset();
        cur_valid = 1'b0; pend_valid = 1'b0; hold = 1'b0;
        cur_idx = 0; pend_left = 0; m_page = 8'hFF;
        exp_active = 1'b0; exp_write = 1'b0; exp_page = 8'hFF;
        q.delete();
    endtask

    task automatic step(input logic w, input logic t, input logic [7:0] d);
        @(posedge clk);
        #1;
        reg_write = w;
        tick      = t;
        d_wr      = d;
        model(w, t, d);
    endtask

    function automatic logic tick_for(input int mode, input int n);
        if (mode == 0) return (n % 4) == 0;
        if (mode == 1) return $urandom_range(0, 2) == 0;
        return 1'b1;
    endfunction

    task automatic run_copy(input int mode, input string name);
        int n = 0;
        while ((cur_valid || pend_valid) && n < 4000) begin
            step(1'b0, tick_for(mode, n), 8'h00);
            n++;
        end
        chk({name, "_done"}, {31'd0, cur_valid || pend_valid}, 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00);
    endtask

    // Scoreboard monitor, sampling away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && !rst) begin
            chk("active", {31'd0, active}, {31'd0, exp_active});
            chk("reg_d_rd", {24'd0, reg_d_rd}, {24'd0, exp_page});
            chk("oam_write", {31'd0, oam_write}, {31'd0, exp_write});
            chk("src_rd", {31'd0, src_rd}, {31'd0, exp_write});
            if (oam_write) begin
                pulses++;
                if (q.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("oam_addr", {24'd0, oam_addr}, {24'd0, e.oa});
                    chk("src_addr", {16'd0, src_addr}, {16'd0, e.sa});
                    chk("oam_d", {24'd0, oam_d}, {24'd0, e.dd});
                end
            end
        end
    end

    initial begin
        int p0;
        int n;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_active", {31'd0, active}, 32'd0);
        chk("rst_write", {31'd0, oam_write}, 32'd0);
        chk("rst_page", {24'd0, reg_d_rd}, 32'h0000_00FF);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        mon_en = 1'b1;

        // Plain copy of page C1, tick every 4 clocks.
        p0 = pulses;
        step(1'b1, 1'b0, 8'hC1);
        run_copy(0, "c1");
        chk("c1_pulses", pulses - p0, LEN);

        // Echo page FE maps to DE.
        step(1'b1, 1'b0, 8'hFE);
        step(1'b0, 1'b0, 8'h00);
        chk("fe_reg", {24'd0, reg_d_rd}, 32'h0000_00FE);
        run_copy(2, "fe");

        // Restart at index 50: old copy finishes idx 50, then new page 80.
        p0 = pulses;
        step(1'b1, 1'b0, 8'hC1);
        n = 0;
        while (!(cur_valid && !pend_valid && cur_idx == 50) && n < 2000) begin
            step(1'b0, tick_for(0, n), 8'h00);
            n++;
        end
        chk("reach_idx50", cur_idx, 50);
        step(1'b1, 1'b0, 8'h80);
        run_copy(0, "restart");
        chk("restart_pulses", pulses - p0, 50 + 1 + LEN);

        // Sparse ticks: index held across gaps.
        p0 = pulses;
        step(1'b1, 1'b0, 8'(($urandom_range(0, 255))));
        run_copy(1, "gaps");
        chk("gap_pulses", pulses - p0, LEN);

        // Write coinciding with a tick in idle.
        step(1'b1, 1'b1, 8'h12);
        run_copy(2, "wr_tick");

        // Reset at index 100.
        step(1'b1, 1'b0, 8'h33);
        n = 0;
        while (!(cur_valid && cur_idx == 100) && n < 2000) begin
            step(1'b0, 1'b1, 8'h00);
            n++;
        end
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        reg_write = 1'b0;
        tick = 1'b1;
        #1;
        chk("pre_rst_write", {31'd0, oam_write}, 32'd1);
        chk("pre_rst_addr", {24'd0, oam_addr}, 32'd100);
        rst = 1'b1;
        #1;
        chk("rst_async_active", {31'd0, active}, 32'd0);
        chk("rst_async_write", {31'd0, oam_write}, 32'd0);
        chk("rst_async_rd", {31'd0, src_rd}, 32'd0);
        chk("rst_async_page", {24'd0, reg_d_rd}, 32'h0000_00FF);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick = 1'b0;
        model_reset();
        mon_en = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'h00);

        // Cold start after reset, echo page E5.
        p0 = pulses;
        step(1'b1, 1'b0, 8'hE5);
        run_copy(1, "cold");
        chk("cold_pulses", pulses - p0, LEN);

        // Random mix of writes and ticks.
        for (int i = 0; i < 2500; i++) begin
            step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)));
        end
        run_copy(2, "soup");

        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
